// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the execute-stage multiply/divide unit.
// The master drives the request and operands. The slave returns stall, result and HI/LO.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [4:0]      alu_function;
  logic            flush;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            illegal_op;

  modport master (
    output req, alu_function, flush, rs_data, rt_data,
    input  stall, busy, result, result_valid, hi, lo, illegal_op
  );

  modport slave (
    input  req, alu_function, flush, rs_data, rt_data,
    output stall, busy, result, result_valid, hi, lo, illegal_op
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning HI/LO, with mf*/mt* access and a pipeline stall.
//   state  | meaning
//   IDLE   | ready; serves mfhi/mflo/mthi/mtlo and starts mult/div
//   MUL    | shift-add, one multiplier bit per cycle
//   DIV    | restoring divide, one quotient bit per cycle
//   FIX    | sign correction and HI/LO write
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [4:0] OP_MFHI  = 5'b00000;
  localparam logic [4:0] OP_MTHI  = 5'b00001;
  localparam logic [4:0] OP_MFLO  = 5'b00010;
  localparam logic [4:0] OP_MTLO  = 5'b00011;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic              rv_q, rv_d, ill_q, ill_d;
  logic              neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d, is_div_q, is_div_d;

  logic              legal, busy, op_signed;
  logic [XLEN-1:0]   a_abs, b_abs, fix_quo, fix_rem;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] fix_prod;

  assign busy             = (state_q != S_IDLE);
  assign bus.busy         = busy;
  assign bus.stall        = bus.req & legal & busy;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.illegal_op   = ill_q;

  always_comb begin
    legal = 1'b0;
    case (bus.alu_function)
      OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase

    op_signed = ~bus.alu_function[0];
    a_abs     = (op_signed && bus.rs_data[XLEN-1]) ? -bus.rs_data : bus.rs_data;
    b_abs     = (op_signed && bus.rt_data[XLEN-1]) ? -bus.rt_data : bus.rt_data;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Partial remainder is always below the divisor, so XLEN+1 bits cannot overflow.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

    fix_prod  = neg_q ? -acc_q : acc_q;
    fix_quo   = div0_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    fix_rem   = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    ill_d     = bus.req & ~bus.flush & ~legal;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;

    if (bus.flush && busy) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req && !bus.flush && legal) begin
            case (bus.alu_function)
              OP_MFHI: begin result_d = hi_q; rv_d = 1'b1; end
              OP_MFLO: begin result_d = lo_q; rv_d = 1'b1; end
              OP_MTHI: hi_d = bus.rs_data;
              OP_MTLO: lo_d = bus.rs_data;
              default: begin
                acc_d     = {{XLEN{1'b0}}, a_abs};
                opb_d     = b_abs;
                cnt_d     = '0;
                is_div_d  = bus.alu_function[1];
                neg_d     = op_signed & (bus.rs_data[XLEN-1] ^ bus.rt_data[XLEN-1]);
                rem_neg_d = op_signed & bus.rs_data[XLEN-1];
                div0_d    = (bus.rt_data == '0);
                state_d   = bus.alu_function[1] ? S_DIV : S_MUL;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
        end
        S_DIV: begin
          if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                  acc_d = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            lo_d = fix_quo;
            hi_d = fix_rem;
          end else begin
            hi_d = fix_prod[2*XLEN-1:XLEN];
            lo_d = fix_prod[XLEN-1:0];
          end
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      ill_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      ill_q     <= ill_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
    end
  end
endmodule
